// File: rtl/reg_rdchan_arbiter_pkg.sv
// Shared types for the register read-channel arbiter: FSM state encoding and
// the helper that sizes requester index fields.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // A single requester still needs a 1-bit index field.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_rdchan_arbiter_if.sv
// Read-channel bundle: per-requester request/response side plus the shared
// downstream regbank read port. The arbiter connects through the slave modport.
interface reg_rdchan_if #(
  parameter int K_NREQ   = 4,
  parameter int K_DWIDTH = 8,
  parameter int K_AWIDTH = 16
);

  logic [K_NREQ*K_AWIDTH-1:0] req_addr;
  logic [K_NREQ-1:0]          req_read;
  logic [K_DWIDTH-1:0]        req_data;
  logic [K_NREQ-1:0]          req_valid;
  logic                       req_timeout;
  logic [K_AWIDTH-1:0]        slv_addr;
  logic                       slv_read;
  logic [K_DWIDTH-1:0]        slv_data;
  logic                       slv_valid;

  modport master (
    output req_addr, req_read, slv_data, slv_valid,
    input  req_data, req_valid, req_timeout, slv_addr, slv_read
  );

  modport slave (
    input  req_addr, req_read, slv_data, slv_valid,
    output req_data, req_valid, req_timeout, slv_addr, slv_read
  );

endinterface

// File: rtl/reg_rdchan_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Zero latency; no backpressure (pure function of req and ptr).
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int K_NREQ = 4,
  parameter int IW     = idx_width(K_NREQ)
) (
  input  logic [K_NREQ-1:0] req,
  input  logic [IW-1:0]     ptr,
  output logic              found,
  output logic [IW-1:0]     idx
);

  logic [IW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest match overwrites last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = K_NREQ - 1; i >= 0; i--) begin
      cand = IW'((int'(ptr) + i) % K_NREQ);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/reg_rdchan_arbiter.sv
// Round-robin arbiter sharing one regbank read port among K_NREQ masters, one read in flight.
// Response 1 cycle after slave valid (min 4 cycles total); waiting masters hold read, timeout bounds a silent slave.
module reg_rdchan_arbiter
  import reg_arb_pkg::*;
#(
  parameter int                  K_NREQ    = 4,
  parameter int                  K_DWIDTH  = 8,
  parameter int                  K_AWIDTH  = 16,
  parameter int                  K_TIMEOUT = 15,
  parameter logic [K_DWIDTH-1:0] K_TO_DATA = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  reg_rdchan_if.slave  bus,
  output logic         o_busy
);

  localparam int              IW       = idx_width(K_NREQ);
  localparam int              CW       = $clog2(K_TIMEOUT + 1);
  localparam logic [CW-1:0]   TO_LAST  = CW'(K_TIMEOUT - 1);
  localparam logic [IW-1:0]   LAST_REQ = IW'(K_NREQ - 1);

  arb_state_e          state, state_nxt;
  logic [IW-1:0]       ptr, grant, pick_idx;
  logic                pick_found;
  logic [K_AWIDTH-1:0] addr_q, pick_addr;
  logic [K_DWIDTH-1:0] data_q;
  logic                to_q;
  logic [CW-1:0]       cnt;
  logic                wait_done;

  rr_pick #(
    .K_NREQ (K_NREQ),
    .IW     (IW)
  ) u_pick (
    .req   (bus.req_read),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    pick_addr = '0;
    for (int r = 0; r < K_NREQ; r++) begin
      if (pick_idx == IW'(r)) pick_addr = bus.req_addr[r*K_AWIDTH +: K_AWIDTH];
    end
  end

  assign wait_done = bus.slv_valid || (cnt == TO_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_found) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (wait_done) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Slave valid beats the timeout when both land in the same WAIT cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ptr    <= '0;
      grant  <= '0;
      addr_q <= '0;
      data_q <= '0;
      to_q   <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant  <= pick_idx;
            addr_q <= pick_addr;
          end
        end
        ISSUE: begin
          cnt  <= '0;
          to_q <= 1'b0;
        end
        WAIT: begin
          cnt <= cnt + CW'(1);
          if (bus.slv_valid) begin
            data_q <= bus.slv_data;
            to_q   <= 1'b0;
          end else if (cnt == TO_LAST) begin
            data_q <= K_TO_DATA;
            to_q   <= 1'b1;
          end
        end
        RESP: begin
          ptr <= (grant == LAST_REQ) ? '0 : grant + IW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.req_valid = '0;
    if (state == RESP) bus.req_valid[grant] = 1'b1;
    bus.req_timeout = (state == RESP) && to_q;
    bus.req_data    = data_q;
    bus.slv_read    = (state == ISSUE);
    bus.slv_addr    = addr_q;
    o_busy          = (state != IDLE);
  end

endmodule

// File: tb/tb_reg_rdchan_arbiter.sv
// Directed bench for reg_rdchan_arbiter: inputs driven and outputs sampled on the falling edge.
module tb_reg_rdchan_arbiter;

  logic clk;
  logic rst_n;
  logic busy;
  int   checks;
  int   failures;

  reg_rdchan_if #(.K_NREQ(4), .K_DWIDTH(8), .K_AWIDTH(16)) bus ();

  reg_rdchan_arbiter #(
    .K_NREQ    (4),
    .K_DWIDTH  (8),
    .K_AWIDTH  (16),
    .K_TIMEOUT (15),
    .K_TO_DATA (8'h00)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus),
    .o_busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_addr(input int r, input logic [15:0] a);
    bus.req_addr[r*16 +: 16] = a;
  endtask

  // Runs one transaction from the current falling edge with reads already set.
  // lat = WAIT cycle (1-based) on which the slave answers, 0 = never.
  // Returns at the falling edge where the response is visible; X/-1 if it never came.
  task automatic txn(input int lat, input logic [7:0] d, output logic [15:0] a,
                     output int gap, output int resp_cyc, output logic [3:0] v,
                     output logic [7:0] rd, output logic to);
    gap = -1; resp_cyc = -1; a = 'x; v = 'x; rd = 'x; to = 1'bx;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (bus.slv_read === 1'b1) begin
        gap = i;
        break;
      end
    end
    if (gap < 0) return;
    a = bus.slv_addr;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (bus.req_valid !== 4'b0000) begin
        resp_cyc = i; v = bus.req_valid; rd = bus.req_data; to = bus.req_timeout;
        bus.slv_valid = 1'b0;
        return;
      end
      if (i == lat) begin
        bus.slv_valid = 1'b1;
        bus.slv_data  = d;
      end else begin
        bus.slv_valid = 1'b0;
      end
    end
    bus.slv_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++; if (bus.req_valid !== 4'b0000) begin failures++; $display("FAIL reset_req_valid: got %b expected 0000", bus.req_valid); end
    checks++; if (bus.req_data !== 8'h00) begin failures++; $display("FAIL reset_req_data: got %h expected 00", bus.req_data); end
    checks++; if (bus.req_timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b expected 0", bus.req_timeout); end
    checks++; if (bus.slv_addr !== 16'h0000) begin failures++; $display("FAIL reset_slv_addr: got %h expected 0000", bus.slv_addr); end
    checks++; if (bus.slv_read !== 1'b0) begin failures++; $display("FAIL reset_slv_read: got %b expected 0", bus.slv_read); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst_n = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_contention();
    logic [15:0] a; logic [3:0] v; logic [7:0] rd; logic to; int gap, rc;
    logic [3:0] exp_v; int g;
    for (int r = 0; r < 4; r++) set_addr(r, 16'h1000 + 16'(r));
    bus.req_read = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      g = k % 4;
      exp_v = 4'b0001 << g;
      txn(1, 8'h30 + 8'(k), a, gap, rc, v, rd, to);
      checks++; if (gap !== ((k == 0) ? 1 : 2)) begin failures++; $display("FAIL cont_gap[%0d]: got %0d expected %0d", k, gap, (k == 0) ? 1 : 2); end
      checks++; if (a !== 16'h1000 + 16'(g)) begin failures++; $display("FAIL cont_addr[%0d]: got %h expected %h", k, a, 16'h1000 + 16'(g)); end
      checks++; if (v !== exp_v) begin failures++; $display("FAIL cont_valid[%0d]: got %b expected %b", k, v, exp_v); end
      checks++; if (rd !== 8'h30 + 8'(k)) begin failures++; $display("FAIL cont_data[%0d]: got %h expected %h", k, rd, 8'h30 + 8'(k)); end
      checks++; if (to !== 1'b0) begin failures++; $display("FAIL cont_timeout[%0d]: got %b expected 0", k, to); end
    end
    bus.req_read = 4'b0000;
    step();
  endtask

  task automatic test_single();
    logic [15:0] a; logic [3:0] v; logic [7:0] rd; logic to; int gap, rc;
    set_addr(1, 16'h0042);
    bus.req_read = 4'b0010;
    txn(2, 8'hA5, a, gap, rc, v, rd, to);
    bus.req_read = 4'b0000;
    checks++; if (gap !== 1) begin failures++; $display("FAIL single_issue_cycle: got %0d expected 1", gap); end
    checks++; if (a !== 16'h0042) begin failures++; $display("FAIL single_slv_addr: got %h expected 0042", a); end
    checks++; if (rc !== 3) begin failures++; $display("FAIL single_resp_cycle: got %0d expected 3", rc); end
    checks++; if (v !== 4'b0010) begin failures++; $display("FAIL single_valid: got %b expected 0010", v); end
    checks++; if (rd !== 8'hA5) begin failures++; $display("FAIL single_data: got %h expected a5", rd); end
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL single_timeout: got %b expected 0", to); end
    step();
    checks++; if (bus.req_valid !== 4'b0000) begin failures++; $display("FAIL single_valid_after: got %b expected 0000", bus.req_valid); end
    checks++; if (bus.req_data !== 8'hA5) begin failures++; $display("FAIL single_data_hold: got %h expected a5", bus.req_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_rr_wrap();
    logic [15:0] a; logic [3:0] v; logic [7:0] rd; logic to; int gap, rc;
    set_addr(2, 16'h2222);
    bus.req_read = 4'b0100;
    txn(1, 8'h61, a, gap, rc, v, rd, to);
    bus.req_read = 4'b0000;
    checks++; if (v !== 4'b0100) begin failures++; $display("FAIL wrap_req2_valid: got %b expected 0100", v); end
    step();
    set_addr(0, 16'h0A00);
    set_addr(3, 16'h3A00);
    bus.req_read = 4'b1001;
    txn(1, 8'h62, a, gap, rc, v, rd, to);
    bus.req_read = 4'b0001;
    checks++; if (v !== 4'b1000) begin failures++; $display("FAIL wrap_first_valid: got %b expected 1000", v); end
    checks++; if (a !== 16'h3A00) begin failures++; $display("FAIL wrap_first_addr: got %h expected 3a00", a); end
    txn(1, 8'h63, a, gap, rc, v, rd, to);
    bus.req_read = 4'b0000;
    checks++; if (v !== 4'b0001) begin failures++; $display("FAIL wrap_second_valid: got %b expected 0001", v); end
    checks++; if (a !== 16'h0A00) begin failures++; $display("FAIL wrap_second_addr: got %h expected 0a00", a); end
    checks++; if (rd !== 8'h63) begin failures++; $display("FAIL wrap_second_data: got %h expected 63", rd); end
    step();
  endtask

  task automatic test_timeout();
    logic [15:0] a; logic [3:0] v; logic [7:0] rd; logic to; int gap, rc;
    set_addr(1, 16'h0111);
    bus.req_read = 4'b0010;
    txn(0, 8'h00, a, gap, rc, v, rd, to);
    bus.req_read = 4'b0000;
    checks++; if (rc !== 16) begin failures++; $display("FAIL to_resp_cycle: got %0d expected 16", rc); end
    checks++; if (v !== 4'b0010) begin failures++; $display("FAIL to_valid: got %b expected 0010", v); end
    checks++; if (to !== 1'b1) begin failures++; $display("FAIL to_flag: got %b expected 1", to); end
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL to_data: got %h expected 00", rd); end
    step();
    set_addr(2, 16'h0222);
    bus.req_read = 4'b0100;
    txn(3, 8'h5C, a, gap, rc, v, rd, to);
    bus.req_read = 4'b0000;
    checks++; if (rc !== 4) begin failures++; $display("FAIL to_next_resp_cycle: got %0d expected 4", rc); end
    checks++; if (v !== 4'b0100) begin failures++; $display("FAIL to_next_valid: got %b expected 0100", v); end
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL to_next_flag: got %b expected 0", to); end
    checks++; if (rd !== 8'h5C) begin failures++; $display("FAIL to_next_data: got %h expected 5c", rd); end
    step();
  endtask

  task automatic test_edge();
    logic [15:0] a; logic [3:0] v; logic [7:0] rd; logic to; int gap, rc;
    set_addr(3, 16'h0333);
    bus.req_read = 4'b1000;
    txn(15, 8'h77, a, gap, rc, v, rd, to);
    bus.req_read = 4'b0000;
    checks++; if (rc !== 16) begin failures++; $display("FAIL edge_resp_cycle: got %0d expected 16", rc); end
    checks++; if (v !== 4'b1000) begin failures++; $display("FAIL edge_valid: got %b expected 1000", v); end
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL edge_timeout: got %b expected 0", to); end
    checks++; if (rd !== 8'h77) begin failures++; $display("FAIL edge_data: got %h expected 77", rd); end
    step();
    bus.slv_valid = 1'b1;
    bus.slv_data  = 8'h99;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.req_valid !== 4'b0000) begin failures++; $display("FAIL stray_valid[%0d]: got %b expected 0000", i, bus.req_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stray_busy[%0d]: got %b expected 0", i, busy); end
    end
    bus.slv_valid = 1'b0;
    step();
    checks++; if (bus.req_data !== 8'h77) begin failures++; $display("FAIL stray_data_hold: got %h expected 77", bus.req_data); end
  endtask

  task automatic test_reset_mid_wait();
    logic [15:0] a; logic [3:0] v; logic [7:0] rd; logic to; int gap, rc;
    bit seen;
    set_addr(1, 16'h0B01);
    bus.req_read = 4'b0010;
    txn(1, 8'h44, a, gap, rc, v, rd, to);
    checks++; if (v !== 4'b0010) begin failures++; $display("FAIL rst_pre_valid: got %b expected 0010", v); end
    set_addr(2, 16'h2BCD);
    bus.req_read = 4'b0100;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.slv_read === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++; if (seen !== 1'b1) begin failures++; $display("FAIL rst_issue_seen: got %b expected 1", seen); end
    repeat (2) step();
    rst_n = 1'b0;
    step();
    checks++; if (bus.req_valid !== 4'b0000) begin failures++; $display("FAIL rst_mid_valid: got %b expected 0000", bus.req_valid); end
    checks++; if (bus.req_data !== 8'h00) begin failures++; $display("FAIL rst_mid_data: got %h expected 00", bus.req_data); end
    checks++; if (bus.slv_addr !== 16'h0000) begin failures++; $display("FAIL rst_mid_slv_addr: got %h expected 0000", bus.slv_addr); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    rst_n = 1'b1;
    bus.req_read = 4'b0000;
    bus.slv_valid = 1'b1;
    bus.slv_data  = 8'hEE;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (bus.req_valid !== 4'b0000) begin failures++; $display("FAIL rst_late_valid[%0d]: got %b expected 0000", i, bus.req_valid); end
    end
    bus.slv_valid = 1'b0;
    for (int r = 0; r < 4; r++) set_addr(r, 16'hC000 + 16'(r));
    bus.req_read = 4'b1111;
    txn(1, 8'h11, a, gap, rc, v, rd, to);
    bus.req_read = 4'b0000;
    checks++; if (v !== 4'b0001) begin failures++; $display("FAIL rst_next_valid: got %b expected 0001", v); end
    checks++; if (a !== 16'hC000) begin failures++; $display("FAIL rst_next_addr: got %h expected c000", a); end
    checks++; if (rd !== 8'h11) begin failures++; $display("FAIL rst_next_data: got %h expected 11", rd); end
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    bus.req_addr  = '0;
    bus.req_read  = '0;
    bus.slv_data  = '0;
    bus.slv_valid = 1'b0;
    test_reset();
    test_contention();
    test_single();
    test_rr_wrap();
    test_timeout();
    test_edge();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
